int_to_fp_pipe: RTL

//  Pipelined, parametrised integer-to-IEEE-754 converter with valid/ready handshakes.

---
 rtl/int_to_fp_pkg.sv | 26 ++
 rtl/int_to_fp_lzc.sv | 25 ++
 rtl/int_to_fp_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/int_to_fp_pkg.sv
// Shared types and elaboration helpers for the integer-to-float converter.
package int_to_fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rmode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/int_to_fp_lzc.sv
// Combinational leading-zero counter; count is WIDTH when the input is all zeros.
module int_to_fp_lzc
  import int_to_fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // Scanning upward lets the highest set bit be the last one to write the count.
  always_comb begin
    count    = CNT_W'(WIDTH);
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count    = CNT_W'(WIDTH - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_to_fp_pipe.sv
// Three-stage integer to IEEE-754 converter with valid/ready handshakes.
// Define INT_TO_FP_RMODE_EN to add a per-beat rmode port; otherwise RNE is fixed.
module int_to_fp_pipe
  import int_to_fp_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_data,
  input  logic                   in_signed,
`ifdef INT_TO_FP_RMODE_EN
  input  logic [1:0]             rmode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_fp,
  output logic                   out_inexact
);

  localparam int FP_W  = fp_width(EXP_W, MAN_W);
  localparam int BIAS  = fp_bias(EXP_W);
  localparam int CNT_W = clog2(INT_W) + 1;
  localparam int EXT_W = INT_W + MAN_W + 1;

  if (INT_W < 2 || INT_W > 64 || MAN_W < 1 || INT_W >= (1 << (EXP_W - 1))) begin : g_bad_params
    $error("int_to_fp_pipe: illegal INT_W/EXP_W/MAN_W combination");
  end

  logic               en;
  logic               in_sign;
  logic [INT_W-1:0]   in_mag;
  rmode_e             in_rmode;

  logic               s1_valid;
  logic               s1_sign;
  logic [INT_W-1:0]   s1_mag;
  rmode_e             s1_rmode;

  logic [CNT_W-1:0]   lzc_count;
  logic               lzc_zero;

  logic               s2_valid;
  logic               s2_sign;
  logic               s2_zero;
  logic [EXP_W-1:0]   s2_idx;
  logic [INT_W-1:0]   s2_norm;
  rmode_e             s2_rmode;

  logic [EXT_W-1:0]   ext;
  logic [MAN_W-1:0]   frac;
  logic               guard;
  logic               sticky;
  logic               inexact;
  logic               round_up;
  logic [MAN_W:0]     frac_rnd;
  logic [EXP_W-1:0]   exp_rnd;
  logic [FP_W-1:0]    result;

  // The whole pipe moves together, so bubbles stay in place while stalled.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign in_sign = in_signed & in_data[INT_W-1];
  assign in_mag  = in_sign ? -in_data : in_data;

`ifdef INT_TO_FP_RMODE_EN
  assign in_rmode = rmode_e'(rmode);
`else
  assign in_rmode = RM_RNE;
`endif

  int_to_fp_lzc #(
    .WIDTH (INT_W),
    .CNT_W (CNT_W)
  ) u_lzc (
    .value    (s1_mag),
    .count    (lzc_count),
    .all_zero (lzc_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_fp      <= '0;
      out_inexact <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_fp      <= result;
        out_inexact <= inexact;
      end
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign  <= in_sign;
      s1_mag   <= in_mag;
      s1_rmode <= in_rmode;
      s2_sign  <= s1_sign;
      s2_zero  <= lzc_zero;
      s2_idx   <= EXP_W'(INT_W - 1 - int'(lzc_count));
      s2_norm  <= s1_mag << lzc_count;
      s2_rmode <= s1_rmode;
    end
  end

  // Bits below the hidden one are padded so guard and sticky exist for any MAN_W.
  always_comb begin
    ext      = {s2_norm[INT_W-2:0], {(MAN_W + 2){1'b0}}};
    frac     = ext[EXT_W-1 -: MAN_W];
    guard    = ext[EXT_W-1-MAN_W];
    sticky   = |ext[EXT_W-2-MAN_W:0];
    inexact  = !s2_zero && (guard || sticky);
    round_up = 1'b0;
    case (s2_rmode)
      RM_RNE:  round_up = guard && (sticky || frac[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RUP:  round_up = (guard || sticky) && !s2_sign;
      default: round_up = (guard || sticky) && s2_sign;
    endcase
    frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    exp_rnd  = s2_idx + EXP_W'(BIAS) + {{(EXP_W - 1){1'b0}}, frac_rnd[MAN_W]};
    result   = s2_zero ? '0 : {s2_sign, exp_rnd, frac_rnd[MAN_W-1:0]};
  end

endmodule
